// File: rtl/direct_mapped_cache_pkg.sv
// rtl/direct_mapped_cache_pkg.sv - shared constants and FSM state type for direct_mapped_cache
// Purpose: default geometry (word width, ram address width, line count) and the
//          controller state encoding, imported by every cache file.
// Ports:   none (package).
package direct_mapped_cache_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RAM_AW = 12;
  localparam int DEF_LINES  = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMP      = 3'd1,
    MEM_WAIT = 3'd2,
    MEM_RD   = 3'd3,
    MEM_WR   = 3'd4,
    RESP     = 3'd5
  } state_t;

endpackage

// File: rtl/direct_mapped_cache_if.sv
// rtl/direct_mapped_cache_if.sv - processor request port and ram initiator port of the cache
// Purpose: bundles the requester handshake and the ram-side bus in one interface.
// Ports:   req/we/addr/wdata in, ready/rdata/hit out (processor side);
//          mem_address/mem_data/mem_write out, mem_out in (ram side).
//          slave  = cache view, master = requester + ram view.
//          All words use [0:DATA_W-1] ordering, bit DATA_W-1 is the LSB.
interface direct_mapped_cache_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [0:DATA_W-1] addr;
  logic [0:DATA_W-1] wdata;
  logic              ready;
  logic [0:DATA_W-1] rdata;
  logic              hit;
  logic [0:DATA_W-1] mem_address;
  logic [0:DATA_W-1] mem_data;
  logic              mem_write;
  logic [0:DATA_W-1] mem_out;

  modport slave (
    input  req, we, addr, wdata, mem_out,
    output ready, rdata, hit, mem_address, mem_data, mem_write
  );

  modport master (
    output req, we, addr, wdata, mem_out,
    input  ready, rdata, hit, mem_address, mem_data, mem_write
  );
endinterface

// File: rtl/direct_mapped_cache_store.sv
// rtl/direct_mapped_cache_store.sv - valid/tag/data arrays of the direct-mapped cache
// Purpose: one-word lines with a combinational read port and a synchronous
//          write port; reset clears every valid bit in one cycle.
// Ports:   clk, reset (sync, active-high);
//          rd_idx_i -> rd_valid_o/rd_tag_o/rd_data_o (combinational);
//          wr_en_i/wr_idx_i/wr_tag_i/wr_data_i (written on rising edge, sets valid).
module direct_mapped_cache_store #(
  parameter int LINES  = 32,
  parameter int IDX_W  = 5,
  parameter int TAG_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [0:DATA_W-1] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [0:DATA_W-1] wr_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [0:DATA_W-1] data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/direct_mapped_cache.sv
// rtl/direct_mapped_cache.sv - direct-mapped write-through write-allocate cache in front of ram
// Purpose: serves read hits locally, fetches read misses from ram, forwards every
//          write to ram and allocates the line. One request at a time.
// Ports:   clk, reset (sync, active-high);
//          bus (slave modport): req/we/addr/wdata -> ready/rdata/hit (all registered),
//          mem_address/mem_data/mem_write -> ram, mem_out <- ram (one-cycle read latency).
module direct_mapped_cache
  import direct_mapped_cache_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int RAM_AW = DEF_RAM_AW,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  direct_mapped_cache_if.slave   bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = RAM_AW - IDX_W;

  state_t              state_q;
  logic                we_q;
  logic [RAM_AW-1:0]   eff_q;
  logic [0:DATA_W-1]   wdata_q;
  logic                ready_q;
  logic                hit_q;
  logic [0:DATA_W-1]   rdata_q;
  logic [0:DATA_W-1]   mem_address_q;
  logic [0:DATA_W-1]   mem_data_q;
  logic                mem_write_q;

  // Only the low RAM_AW address bits reach ram, so the cache aliases the same way.
  logic [RAM_AW-1:0]   req_eff;
  logic                unused_addr_hi;
  assign req_eff        = bus.addr[DATA_W-RAM_AW +: RAM_AW];
  assign unused_addr_hi = ^bus.addr[0:DATA_W-RAM_AW-1];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [0:DATA_W-1]   eff_ext;
  assign idx     = eff_q[IDX_W-1:0];
  assign tag     = eff_q[RAM_AW-1:IDX_W];
  assign eff_ext = {{(DATA_W-RAM_AW){1'b0}}, eff_q};

  logic                st_valid;
  logic [TAG_W-1:0]    st_tag;
  logic [0:DATA_W-1]   st_data;
  logic                tag_match;
  logic                st_we;
  logic [0:DATA_W-1]   st_wdata;

  assign tag_match = st_valid && (st_tag == tag);

  // Lines are allocated on every write (in CMP) and on every read fill (in MEM_RD).
  assign st_we    = ((state_q == CMP) && we_q) || (state_q == MEM_RD);
  assign st_wdata = (state_q == MEM_RD) ? bus.mem_out : wdata_q;

  direct_mapped_cache_store #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (idx),
    .rd_valid_o (st_valid),
    .rd_tag_o   (st_tag),
    .rd_data_o  (st_data),
    .wr_en_i    (st_we),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (st_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      eff_q         <= '0;
      wdata_q       <= '0;
      ready_q       <= 1'b0;
      hit_q         <= 1'b0;
      rdata_q       <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_write_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            eff_q   <= req_eff;
            wdata_q <= bus.wdata;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (!we_q && tag_match) begin
            rdata_q <= st_data;
            hit_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= RESP;
          end else if (!we_q) begin
            mem_address_q <= eff_ext;
            mem_write_q   <= 1'b0;
            state_q       <= MEM_WAIT;
          end else begin
            mem_address_q <= eff_ext;
            mem_data_q    <= wdata_q;
            mem_write_q   <= 1'b1;
            hit_q         <= tag_match;
            state_q       <= MEM_WR;
          end
        end
        // ram registers the address on this edge; its output is usable one edge later.
        MEM_WAIT: state_q <= MEM_RD;
        MEM_RD: begin
          rdata_q <= bus.mem_out;
          hit_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= RESP;
        end
        MEM_WR: begin
          mem_write_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.hit         = hit_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_write   = mem_write_q;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb/tb_direct_mapped_cache.sv - self-checking bench for direct_mapped_cache
module tb_direct_mapped_cache;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  direct_mapped_cache_if #(.DATA_W(32)) bus ();

  direct_mapped_cache #(.LINES(32), .RAM_AW(12), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ram: write on the rising edge, registered read output.
  logic [31:0] ram_mem [4096] = '{default: 32'd0};
  always @(posedge clk) begin
    if (bus.mem_write) ram_mem[bus.mem_address[20:31]] <= bus.mem_data;
    bus.mem_out <= ram_mem[bus.mem_address[20:31]];
  end

  // Reference model: which word each line holds (-1 = empty) and ram contents.
  int          line_word [32];
  logic [31:0] shadow [4096] = '{default: 32'd0};
  logic [31:0] last_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    bit          rst;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    bit          h;
    logic [31:0] rd;
    logic [31:0] ma;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) line_word[i] = -1;
    last_rdata = '0;
  endtask

  task automatic model_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output bit h, output logic [31:0] rd);
    int word;
    int line;
    word = int'(a % 32'd4096);
    line = word % 32;
    h = (line_word[line] == word);
    if (w) begin
      lat = 2;
      rd  = last_rdata;
      shadow[word] = d;
    end else begin
      lat = h ? 1 : 3;
      rd  = shadow[word];
      last_rdata = rd;
    end
    line_word[line] = word;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, {31'd0, bus.ready}, 0);
    check({tag, "_hit"}, {31'd0, bus.hit}, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_mem_address"}, bus.mem_address, 0);
    check({tag, "_mem_data"}, bus.mem_data, 0);
    check({tag, "_mem_write"}, {31'd0, bus.mem_write}, 0);
  endtask

  task automatic pulse_reset(input bit chk);
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    if (chk) check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output bit h, output logic [31:0] rd,
                         output int mwc, output logic [31:0] ma, output logic [31:0] md);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    lat = -1; mwc = 0; ma = '0; md = '0; h = 1'b0; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_write) begin
        mwc++;
        ma = bus.mem_address;
        md = bus.mem_data;
      end
      if (bus.ready) begin
        lat = c;
        h   = bus.hit;
        rd  = bus.rdata;
        bus.req = 1'b0;
        break;
      end
    end
    if (lat < 0) begin
      bus.req = 1'b0;
      total++;
      bad++;
      $display("FAIL txn_timeout: got no ready expected ready within 20 cycles");
    end else begin
      @(posedge clk);
      #1;
      check("ready_one_cycle", {31'd0, bus.ready}, 0);
    end
  endtask

  // Runs one transaction and compares it against the reference model.
  task automatic model_check(input string name, input bit w, input logic [31:0] a, input logic [31:0] d);
    int lat, elat, mwc;
    bit h, eh;
    logic [31:0] rd, erd, ma, md;
    model_txn(w, a, d, elat, eh, erd);
    run_txn(w, a, d, lat, h, rd, mwc, ma, md);
    check({name, "_lat"}, lat, elat);
    check({name, "_hit"}, {31'd0, h}, {31'd0, eh});
    check({name, "_rdata"}, rd, erd);
    check({name, "_mwcount"}, mwc, w ? 1 : 0);
    if (w) begin
      check({name, "_maddr"}, ma, a % 32'd4096);
      check({name, "_mdata"}, md, d);
    end
  endtask

  initial begin
    int lat, mwc, cnt;
    bit h;
    bit ew;
    logic [31:0] rd, ma, md, a, d;
    int elat;
    bit eh;
    logic [31:0] erd;

    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("por");
    @(negedge clk);
    reset = 1'b0;

    vecs.push_back('{"wr0",          0, 1, 32'd0,          32'd14528,    2, 0, 32'd0,        32'd0});
    vecs.push_back('{"rd0",          0, 0, 32'd0,          32'd0,        1, 1, 32'd14528,    32'd0});
    vecs.push_back('{"wr3036",       0, 1, 32'd2816867292, 32'd526421,   2, 0, 32'd0,        32'd3036});
    vecs.push_back('{"rd3036_miss",  1, 0, 32'd3036,       32'd0,        3, 0, 32'd526421,   32'd0});
    vecs.push_back('{"rd3036_hit",   0, 0, 32'd3036,       32'd0,        1, 1, 32'd526421,   32'd0});
    vecs.push_back('{"wr28",         0, 1, 32'd28,         32'd5,        2, 0, 32'd0,        32'd28});
    vecs.push_back('{"rd3036_evict", 0, 0, 32'd3036,       32'd0,        3, 0, 32'd526421,   32'd0});
    vecs.push_back('{"rd28_evict",   0, 0, 32'd28,         32'd0,        3, 0, 32'd5,        32'd0});
    vecs.push_back('{"wr_alias",     0, 1, 32'd1001425,    32'd25369366, 2, 0, 32'd0,        32'd2001});
    vecs.push_back('{"rd2001",       0, 0, 32'd2001,       32'd0,        1, 1, 32'd25369366, 32'd0});
    vecs.push_back('{"rd3036_fill",  0, 0, 32'd3036,       32'd0,        3, 0, 32'd526421,   32'd0});
    vecs.push_back('{"wr3036_over",  0, 1, 32'd3036,       32'd14528,    2, 1, 32'd0,        32'd3036});
    vecs.push_back('{"rd3036_over",  0, 0, 32'd3036,       32'd0,        1, 1, 32'd14528,    32'd0});

    foreach (vecs[i]) begin
      if (vecs[i].rst) pulse_reset(1'b1);
      model_txn(vecs[i].w, vecs[i].a, vecs[i].d, elat, eh, erd);
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d, lat, h, rd, mwc, ma, md);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_hit"}, {31'd0, h}, {31'd0, vecs[i].h});
      check({vecs[i].name, "_mwcount"}, mwc, vecs[i].w ? 1 : 0);
      if (vecs[i].w) begin
        check({vecs[i].name, "_maddr"}, ma, vecs[i].ma);
        check({vecs[i].name, "_mdata"}, md, vecs[i].d);
        check({vecs[i].name, "_rdata_kept"}, rd, erd);
      end else begin
        check({vecs[i].name, "_rdata"}, rd, vecs[i].rd);
      end
    end
    @(negedge clk);
    check("ram_word_3036", ram_mem[3036], 32'd14528);

    // Reset while a read miss sits in MEM_WAIT.
    model_check("mid_fillA", 1'b1, 32'd100, 32'd11);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'd7;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_no_early_ready", {31'd0, bus.ready}, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.ready) cnt++;
    end
    check("mid_no_ready_after_abort", cnt, 0);
    model_check("mid_readA_after", 1'b0, 32'd100, 32'd0);
    model_check("mid_read7_after", 1'b0, 32'd7, 32'd0);

    // Reset and req in the same cycle: the request must not be latched.
    @(negedge clk);
    reset = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'd50; bus.wdata = 32'd99;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req = 1'b0;
    model_reset();
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.ready || bus.mem_write) cnt++;
    end
    check("rst_req_not_latched", cnt, 0);
    model_check("rst_req_read50", 1'b0, 32'd50, 32'd0);

    // Randomized traffic over a small set of tags so hits and conflicts both occur.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset(1'b1);
      a = $urandom;
      if ($urandom_range(0, 9) == 0) a[11:0] = 12'($urandom_range(0, 4095));
      else a[11:0] = 12'($urandom_range(0, 3) * 32 + $urandom_range(0, 31));
      d  = $urandom;
      ew = ($urandom_range(0, 2) == 0);
      model_check($sformatf("rnd%0d", n), ew, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
